f16_acc: RTL

F16_ACC -- requirements
Module: f16_acc

---
 rtl/f16_acc.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/f16_acc.sv
// Streaming float16 accumulator: sums LEN products per frame, RNE adds.
// Define F16_ACC_FTZ_EN to flush subnormal inputs and results to zero.
module f16_acc #(
   parameter int LEN = 16,
   localparam int CW = $clog2(LEN + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          DVI,
   input  logic [15:0]   DI,
   input  logic [5:0]    DI_TYPE,
   input  logic          FLUSH,
   output logic          DVO,
   output logic [15:0]   SUM,
   output logic [5:0]    SUM_TYPE,
   output logic [CW-1:0] CNT
);

   typedef enum logic {IDLE, ACC} state_t;

   state_t        state_q, state_d;
   logic [15:0]   acc_q;
   logic [CW-1:0] cnt_q;
   logic          nan_q;

   logic [15:0]   din;
   logic          in_nan;
   logic [15:0]   sum_new;
   logic [CW-1:0] cnt_new;
   logic          nan_new;
   logic          fin;
   logic [15:0]   res_sum;
   logic [CW-1:0] res_cnt;

   function automatic logic [5:0] f16_class(input logic [15:0] v);
      logic ez, eo, fz;
      logic [5:0] c;
      ez = (v[14:10] == 5'd0);
      eo = (v[14:10] == 5'h1F);
      fz = (v[9:0] == 10'd0);
      c = 6'b100000;
      unique case (1'b1)
         eo && !fz: c = 6'b000010;
         eo && fz:  c = 6'b000100;
         ez && fz:  c = 6'b001000;
         ez && !fz: c = 6'b010000;
         default:   c = 6'b100000;
      endcase
      return c;
   endfunction

   // One binary16 add, round to nearest-even, three guard bits (G,R,sticky)
   function automatic logic [15:0] fadd(input logic [15:0] a,
                                        input logic [15:0] b);
      logic        a_nan, b_nan, a_inf, b_inf, swap, sub, rup;
      logic [15:0] l, s;
      logic [5:0]  el, es, e, d;
      logic [3:0]  dc, lz, sft;
      logic [13:0] ml, ms, msh, m;
      logic [28:0] sh;
      logic [14:0] sum;
      logic [11:0] rs;
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
      if (a_nan || b_nan) return 16'h7E00;
      if (a_inf && b_inf && (a[15] != b[15])) return 16'h7E00;
      if (a_inf) return a;
      if (b_inf) return b;
      swap = (b[14:0] > a[14:0]);
      l = swap ? b : a;
      s = swap ? a : b;
      el = (l[14:10] == 5'd0) ? 6'd1 : {1'b0, l[14:10]};
      es = (s[14:10] == 5'd0) ? 6'd1 : {1'b0, s[14:10]};
      ml = {(l[14:10] != 5'd0), l[9:0], 3'b000};
      ms = {(s[14:10] != 5'd0), s[9:0], 3'b000};
      d = el - es;
      dc = (d > 6'd15) ? 4'd15 : d[3:0];
      sh = {ms, 15'd0} >> dc;
      msh = sh[28:15] | {13'd0, |sh[14:0]};
      sub = l[15] ^ s[15];
      sum = sub ? ({1'b0, ml} - {1'b0, msh})
                : ({1'b0, ml} + {1'b0, msh});
      if (sum == 15'd0) return {l[15] & s[15], 15'd0};
      e = el;
      if (sum[14]) begin
         m = sum[14:1] | {13'd0, sum[0]};
         e = e + 6'd1;
      end else begin
         lz = 4'd13;
         for (int i = 0; i <= 13; i++)
            if (sum[i]) lz = 4'(13 - i);
         // never shift below the minimum exponent: gradual underflow
         if ({2'b00, lz} > (e - 6'd1)) sft = 4'(e - 6'd1);
         else sft = lz;
         m = sum[13:0] << sft;
         e = e - {2'b00, sft};
      end
      rup = m[2] & (m[1] | m[0] | m[3]);
      rs = {1'b0, m[13:3]} + {11'd0, rup};
      if (rs[11]) begin
         e = e + 6'd1;
         rs = rs >> 1;
      end
      if (!rs[10]) e = 6'd0;
      if (e >= 6'd31) return {l[15], 5'h1F, 10'd0};
`ifdef F16_ACC_FTZ_EN
      if (e == 6'd0) return {l[15], 15'd0};
`endif
      return {l[15], e[4:0], rs[9:0]};
   endfunction

   always_comb begin
      din = DI;
      unique case (1'b1)
         DI_TYPE[5]: din = DI;
`ifdef F16_ACC_FTZ_EN
         DI_TYPE[4]: din = {DI[15], 15'd0};
`else
         DI_TYPE[4]: din = DI;
`endif
         DI_TYPE[3]: din = {DI[15], 15'd0};
         DI_TYPE[2]: din = {DI[15], 5'h1F, 10'd0};
         DI_TYPE[1]: din = 16'h7E00;
         DI_TYPE[0]: din = 16'h7E00;
         default:    din = DI;
      endcase
   end

   assign in_nan  = DI_TYPE[1] | DI_TYPE[0];
   assign sum_new = (state_q == IDLE) ? din : fadd(acc_q, din);
   assign cnt_new = cnt_q + CW'(1);
   assign nan_new = nan_q | in_nan;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (DVI && !fin) state_d = ACC;
         ACC:     if (fin) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fin     = 1'b0;
      res_sum = acc_q;
      res_cnt = cnt_q;
      if (DVI) begin
         fin     = FLUSH || (cnt_new == CW'(LEN));
         res_sum = nan_new ? 16'h7E00 : sum_new;
         res_cnt = cnt_new;
      end else begin
         fin     = FLUSH && (state_q == ACC);
         res_sum = nan_q ? 16'h7E00 : acc_q;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q    <= 16'h0000;
         cnt_q    <= '0;
         nan_q    <= 1'b0;
         DVO      <= 1'b0;
         SUM      <= 16'h0000;
         SUM_TYPE <= 6'b001000;
         CNT      <= '0;
      end else begin
         DVO <= fin;
         if (fin) begin
            SUM      <= res_sum;
            SUM_TYPE <= f16_class(res_sum);
            CNT      <= res_cnt;
            acc_q    <= 16'h0000;
            cnt_q    <= '0;
            nan_q    <= 1'b0;
         end else if (DVI) begin
            acc_q <= sum_new;
            cnt_q <= cnt_new;
            nan_q <= nan_new;
         end
      end
   end

endmodule
